// File: rtl/pc_unit.sv
// Program counter with sequential/relative/absolute updates and a circular
// return-address stack for CALL/RET, plus a sticky overflow/underflow flag.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             operand,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
  output logic                         err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_BREL = 3'b001,
    OP_JABS = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  // wr_ptr names the slot the next push lands in; when full it is the oldest entry.
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] seq_pc;

  logic [WIDTH-1:0] pc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [PW-1:0]    ptr_nxt;
  logic             err_nxt;
  logic             push;

  assign seq_pc    = pc + WIDTH'(STEP);
  assign rd_ptr    = wr_ptr - PW'(1);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  always_comb begin
    pc_nxt  = seq_pc;
    cnt_nxt = ras_count;
    ptr_nxt = wr_ptr;
    err_nxt = err;
    push    = 1'b0;
    case (op)
      OP_BREL: pc_nxt = pc + operand;
      OP_JABS: pc_nxt = operand;
      OP_CALL: begin
        pc_nxt  = operand;
        push    = 1'b1;
        ptr_nxt = wr_ptr + PW'(1);
        if (ras_full) begin
          err_nxt = 1'b1;
        end else begin
          cnt_nxt = ras_count + CW'(1);
        end
      end
      OP_RET: begin
        if (ras_empty) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt  = ras_mem[rd_ptr];
          ptr_nxt = rd_ptr;
          cnt_nxt = ras_count - CW'(1);
        end
      end
      default: pc_nxt = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      ras_count <= '0;
      wr_ptr    <= '0;
      err       <= 1'b0;
    end else if (en) begin
      pc        <= pc_nxt;
      ras_count <= cnt_nxt;
      wr_ptr    <= ptr_nxt;
      err       <= err_nxt;
    end
  end

  // Stack storage carries no reset; entries are only read while ras_count covers them.
  always_ff @(posedge clk) begin
    if (en && push && rst_n) begin
      ras_mem[wr_ptr] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized ops against a queue-based model.
module tb_pc_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand = '0;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_err;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .operand(operand),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
    .ras_empty(ras_empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one op on a negedge, let the posedge act, advance the model, sample 1ns later.
  task automatic do_op(input logic e, input logic [2:0] o, input logic [31:0] d);
    @(negedge clk);
    en = e; op = o; operand = d;
    @(posedge clk);
    if (e) begin
      case (o)
        3'd1: m_pc = m_pc + d;
        3'd2: m_pc = d;
        3'd3: begin
          m_q.push_back(m_pc + 32'd4);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
          end
          m_pc = d;
        end
        3'd4: begin
          if (m_q.size() == 0) begin
            m_pc = m_pc + 32'd4;
            m_err = 1'b1;
          end else begin
            m_pc = m_q.pop_back();
          end
        end
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
    checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", ras_count); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_empty actual=%b required=1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin failures++; $display("FAIL reset_full actual=%b required=0", ras_full); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b required=0", err); end
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      do_op(1'b1, 3'd0, 32'h0);
      checks++; if (pc !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc actual=%h required=%h", pc, 32'(i * 4)); end
    end
    checks++; if (ras_empty !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL seq_flags actual=%b%b required=10", ras_empty, err); end
  endtask

  task automatic test_branch_jump();
    do_op(1'b1, 3'd2, 32'h100);
    do_op(1'b1, 3'd1, 32'hFFFF_FFF0);
    checks++; if (pc !== 32'h0F0) begin failures++; $display("FAIL brel_back actual=%h required=%h", pc, 32'h0F0); end
    do_op(1'b1, 3'd2, 32'h2000);
    checks++; if (pc !== 32'h2000) begin failures++; $display("FAIL jabs actual=%h required=%h", pc, 32'h2000); end
    do_op(1'b1, 3'd2, 32'hFFFF_FFFC);
    do_op(1'b1, 3'd0, 32'h1234);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL seq_wrap actual=%h required=%h", pc, 32'h0); end
    do_op(1'b1, 3'd7, 32'h5555);
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL op7_as_seq actual=%h required=%h", pc, 32'h4); end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_op(1'b1, 3'd2, 32'h40);
    do_op(1'b1, 3'd3, 32'h800);
    checks++; if (pc !== 32'h800 || ras_count !== 3'd1) begin failures++; $display("FAIL call actual=%h/%0d required=800/1", pc, ras_count); end
    do_op(1'b1, 3'd0, 32'h0);
    checks++; if (pc !== 32'h804) begin failures++; $display("FAIL call_seq actual=%h required=804", pc); end
    do_op(1'b1, 3'd4, 32'h0);
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL ret_pc actual=%h required=44", pc); end
    checks++; if (ras_empty !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL ret_flags actual=%b%b required=10", ras_empty, err); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) do_op(1'b1, 3'd3, 32'h1000 + 32'(i));
    checks++; if (ras_full !== 1'b1 || err !== 1'b1 || ras_count !== 3'd4) begin
      failures++; $display("FAIL overflow_flags actual=full%b err%b cnt%0d required=full1 err1 cnt4", ras_full, err, ras_count);
    end
    checks++; if (pc !== 32'h1004) begin failures++; $display("FAIL overflow_pc actual=%h required=1004", pc); end
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 3'd4, 32'h0);
      checks++; if (pc !== 32'h1007 - 32'(i)) begin failures++; $display("FAIL lifo_ret actual=%h required=%h", pc, 32'h1007 - 32'(i)); end
    end
    do_op(1'b1, 3'd4, 32'h0);
    checks++; if (pc !== 32'h1008 || ras_count !== 3'd0 || err !== 1'b1) begin
      failures++; $display("FAIL underflow_after_drain actual=%h/%0d/%b required=1008/0/1", pc, ras_count, err);
    end
  endtask

  task automatic test_underflow_sticky();
    do_reset();
    do_op(1'b1, 3'd2, 32'h20);
    do_op(1'b1, 3'd4, 32'h0);
    checks++; if (pc !== 32'h24 || err !== 1'b1 || ras_count !== 3'd0) begin
      failures++; $display("FAIL ret_empty actual=%h/%b/%0d required=24/1/0", pc, err, ras_count);
    end
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 3'd0, 32'h0);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky actual=%b required=1", err); end
    end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared actual=%b required=0", err); end
  endtask

  task automatic test_stall_async_reset();
    do_reset();
    do_op(1'b1, 3'd2, 32'h300);
    do_op(1'b1, 3'd3, 32'h500);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 3'd3, 32'h900);
      checks++; if (pc !== 32'h500 || ras_count !== 3'd1) begin
        failures++; $display("FAIL stall actual=%h/%0d required=500/1", pc, ras_count);
      end
    end
    // Mid-cycle reset must act before the next rising edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (pc !== 32'h0 || ras_count !== 3'd0 || err !== 1'b0) begin
      failures++; $display("FAIL async_reset actual=%h/%0d/%b required=0/0/0", pc, ras_count, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 3'd0, 32'h0);
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL first_after_reset actual=%h required=4", pc); end
    // Reset held across an edge carrying a CALL wins.
    @(negedge clk);
    en = 1'b1; op = 3'd3; operand = 32'h777;
    #4 rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++; if (pc !== 32'h0 || ras_count !== 3'd0) begin
      failures++; $display("FAIL reset_priority actual=%h/%0d required=0/0", pc, ras_count);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] d;
    logic        e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        e = ($urandom_range(0, 9) != 0);
        o = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) o = 3'd4;
        d = $urandom;
        if (o == 3'd1) d = 32'($signed($urandom_range(0, 512)) - 256);
        do_op(e, o, d);
      end
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc iter=%0d actual=%h required=%h", i, pc, m_pc); end
      checks++; if (ras_count !== 3'(m_q.size())) begin failures++; $display("FAIL rand_count iter=%0d actual=%0d required=%0d", i, ras_count, m_q.size()); end
      checks++; if (ras_full !== (m_q.size() == DEPTH)) begin failures++; $display("FAIL rand_full iter=%0d actual=%b", i, ras_full); end
      checks++; if (ras_empty !== (m_q.size() == 0)) begin failures++; $display("FAIL rand_empty iter=%0d actual=%b", i, ras_empty); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err iter=%0d actual=%b required=%b", i, err, m_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seq();
    test_branch_jump();
    test_call_ret();
    test_overflow();
    test_underflow_sticky();
    test_stall_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC and operand width in bits (legal 8..64).
REQ-002 The block SHALL have parameter STEP, default 4, giving the sequential increment in bytes.
REQ-003 The block SHALL have parameter RESET_VEC, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack entry count (power of 2, 2..16).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: advance enable; 0 = stall.
REQ-008 The block SHALL have port op, input, 3 bits: 000 SEQ, 001 BREL, 010 JABS, 011 CALL, 100 RET; 101..111 are treated as SEQ.
REQ-009 The block SHALL have port operand, input, WIDTH bits: signed offset for BREL, absolute target for JABS and CALL.
REQ-010 The block SHALL have port pc, output, WIDTH bits: current program counter, driven directly from a register.
REQ-011 The block SHALL have port ras_count, output, $clog2(RAS_DEPTH)+1 bits: valid stack entries.
REQ-012 The block SHALL have port ras_full, output, 1 bit: ras_count == RAS_DEPTH.
REQ-013 The block SHALL have port ras_empty, output, 1 bit: ras_count == 0.
REQ-014 The block SHALL have port err, output, 1 bit: sticky stack overflow/underflow flag.

Function
REQ-015 The block SHALL update pc, the stack, ras_count and err only on a rising clk edge with en=1; with en=0 all state SHALL hold and op/operand SHALL be ignored.
REQ-016 On SEQ the block SHALL load pc <= pc + STEP, modulo 2^WIDTH (wrap, no flag).
REQ-017 On BREL the block SHALL load pc <= pc + operand, with operand two's complement, modulo 2^WIDTH.
REQ-018 On JABS the block SHALL load pc <= operand.
REQ-019 On CALL the block SHALL push (pc + STEP) mod 2^WIDTH, load pc <= operand, and increment ras_count, all in the same edge.
REQ-020 On CALL with ras_full=1 the block SHALL overwrite the oldest entry (circular), hold ras_count at RAS_DEPTH, set err, and still load pc <= operand.
REQ-021 On RET with ras_empty=0 the block SHALL load pc <= most recently pushed entry and decrement ras_count.
REQ-022 On RET with ras_empty=1 the block SHALL load pc <= pc + STEP, keep ras_count at 0, and set err.
REQ-023 The block SHALL make new pc, ras_count, ras_full and ras_empty visible immediately after the updating edge (one-cycle latency, no combinational path from inputs to outputs).
REQ-024 Once set, err SHALL remain 1 until reset.
REQ-025 Under LIFO order, after N overflowing CALLs the last RAS_DEPTH pushes SHALL be retrievable newest-first.

Reset
REQ-026 When rst_n=0 the block SHALL immediately, independent of clk, set pc=RESET_VEC, ras_count=0, ras_empty=1, ras_full=0, err=0; stack entry contents are don't-care.
REQ-027 A rst_n assertion coinciding with any op SHALL take priority; no update from that edge SHALL survive.
REQ-028 After rst_n deasserts, the first rising edge with en=1 SHALL perform a normal update from RESET_VEC.

Verification
REQ-029 Reset then 3 SEQ cycles, defaults -> pc = 0, 4, 8, 12; ras_empty=1, err=0.
REQ-030 pc=0x100, BREL operand=0xFFFFFFF0 -> pc=0x0F0; then JABS 0x2000 -> pc=0x2000; pc=0xFFFFFFFC then SEQ -> pc=0x0.
REQ-031 pc=0x40, CALL 0x800 -> pc=0x800, ras_count=1; SEQ -> 0x804; RET -> pc=0x44, ras_empty=1, err=0.
REQ-032 5 CALLs (RAS_DEPTH=4) to 0x1000..0x1004 from successive returns -> ras_full=1, err=1, ras_count=4; 4 RETs return newest-first, 5th RET -> pc+4, ras_count=0.
REQ-033 RET on empty stack at pc=0x20 -> pc=0x24, err=1, remains 1 through later SEQ until rst_n pulse clears it.
REQ-034 en=0 with CALL held 3 cycles -> pc and ras_count unchanged; rst_n pulsed low mid-cycle -> pc=RESET_VEC before next clk edge.
